// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit path (and reusable by the
// receive path): parity selection, baud divisor rounding and the one-hot
// transmitter state encoding.
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'd0,
      PARITY_ODD  = 2'd1,
      PARITY_EVEN = 2'd2
   } parity_t;

   // One-hot transmitter states.
   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_START  = 5'b00010,
      S_DATA   = 5'b00100,
      S_PARITY = 5'b01000,
      S_STOP   = 5'b10000
   } tx_state_e;

   // Clocks per line bit, rounded to nearest so RX and TX agree exactly.
   function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
      return (clk_freq + baud_rate / 2) / baud_rate;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Restartable bit-period down-counter.
//   clk       : system clock
//   n_rst     : asynchronous active-low reset
//   i_start   : load the counter with CLKS_PER_BIT (restart a bit period)
//   o_bit_end : high during the last clock of a bit period
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic n_rst,
   input  logic i_start,
   output logic o_bit_end
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (i_start) begin
         cnt_d = CNT_W'(CLKS_PER_BIT);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Loading CLKS_PER_BIT and ending at 1 gives exactly CLKS_PER_BIT clocks
   // per period when restarted on the end pulse.
   assign o_bit_end = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity bit, STOP_BITS stop bits. One word in flight, valid/ready accept.
//   clk          : system clock
//   n_rst        : asynchronous active-low reset
//   i_data_valid : client offers a word
//   i_data       : word, sampled on the accept cycle only
//   o_ready      : block is idle and can accept a word
//   o_tx         : registered serial line, idle high
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 115200,
   parameter int DATA_BITS = 8,
   parameter int STOP_BITS = 1,
   parameter int PARITY    = 0
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 i_data_valid,
   input  logic [DATA_BITS-1:0] i_data,
   output logic                 o_ready,
   output logic                 o_tx
);

   localparam int CPB    = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int BCNT_W = $clog2(DATA_BITS + 1);

   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx: DATA_BITS must be in 5..9");
   end

   tx_state_e            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic                 tx_q, tx_d;
   logic                 accept;
   logic                 bit_end;
   logic                 timer_start;

   uart_bit_timer #(
      .CLKS_PER_BIT(CPB)
   ) u_bit_timer (
      .clk      (clk),
      .n_rst    (n_rst),
      .i_start  (timer_start),
      .o_bit_end(bit_end)
   );

   // State register
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         par_q     <= 1'b0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
      end
   end

   // Next-state logic. bit_cnt counts data bits in DATA and stop bits in STOP.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      par_d       = par_q;
      bit_cnt_d   = bit_cnt_q;
      accept      = i_data_valid && (state_q == S_IDLE);
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               shift_d   = i_data;
               par_d     = (PARITY == int'(PARITY_EVEN)) ? ^i_data : ~^i_data;
               bit_cnt_d = '0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == BCNT_W'(DATA_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY != int'(PARITY_NONE)) ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCNT_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               bit_cnt_d = '0;
               state_d   = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (bit_cnt_q == BCNT_W'(STOP_BITS - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = S_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCNT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Restart the period on accept and on every bit end except the last.
      timer_start = accept || (bit_end && (state_d != S_IDLE));
   end

   // Output logic. The line level is registered from the current state, so
   // o_tx trails the state by one clock while o_ready follows it directly.
   always_comb begin
      tx_d    = 1'b1;
      o_ready = (state_q == S_IDLE);
      unique case (state_q)
         S_IDLE:   tx_d = 1'b1;
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_q[0];
         S_PARITY: tx_d = par_q;
         S_STOP:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

   assign o_tx = tx_q;

endmodule
